// File: rtl/matmul_engine_pkg.sv
// -----------------------------------------------------------------------------
// matmul_engine_pkg
// Shared definitions for the matrix-multiply engine: default parameter values
// and the controller state encoding.
// -----------------------------------------------------------------------------
package matmul_engine_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH  = 12;
    localparam int DEF_MAX_LEN     = 100;
    localparam int DEF_MAX_LEN_LOG = 7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/matmul_addr_gen.sv
// -----------------------------------------------------------------------------
// matmul_addr_gen
// Row/column/inner-product counters (i, j, p) and the A, B and C word
// addresses derived from them.
//   clk, rst_n        clock, asynchronous active-low reset
//   clear             zero all counters
//   p_inc             advance p (wraps to 0 after K-1)
//   elem_next         move to the next C element (row-major), p back to 0
//   dim_m/k/n         latched matrix dimensions
//   a/b/c_base        latched base addresses
//   a_addr            a_base + i*K + p
//   b_addr            b_base + p*N + j
//   c_addr            c_base + i*N + j
//   last_p            p == K-1
//   last_elem         i == M-1 and j == N-1
// -----------------------------------------------------------------------------
module matmul_addr_gen
    import matmul_engine_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int MAX_LEN_LOG = DEF_MAX_LEN_LOG
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   p_inc,
    input  logic                   elem_next,
    input  logic [MAX_LEN_LOG-1:0] dim_m,
    input  logic [MAX_LEN_LOG-1:0] dim_k,
    input  logic [MAX_LEN_LOG-1:0] dim_n,
    input  logic [ADDR_WIDTH-1:0]  a_base,
    input  logic [ADDR_WIDTH-1:0]  b_base,
    input  logic [ADDR_WIDTH-1:0]  c_base,
    output logic [ADDR_WIDTH-1:0]  a_addr,
    output logic [ADDR_WIDTH-1:0]  b_addr,
    output logic [ADDR_WIDTH-1:0]  c_addr,
    output logic                   last_p,
    output logic                   last_elem
);

    logic [MAX_LEN_LOG-1:0] i_q, i_d;
    logic [MAX_LEN_LOG-1:0] j_q, j_d;
    logic [MAX_LEN_LOG-1:0] p_q, p_d;
    logic                   last_j;

    assign last_p    = (p_q == dim_k - MAX_LEN_LOG'(1));
    assign last_j    = (j_q == dim_n - MAX_LEN_LOG'(1));
    assign last_elem = last_j && (i_q == dim_m - MAX_LEN_LOG'(1));

    always_comb begin
        i_d = i_q;
        j_d = j_q;
        p_d = p_q;
        if (clear) begin
            i_d = '0;
            j_d = '0;
            p_d = '0;
        end else begin
            if (p_inc) begin
                p_d = last_p ? '0 : p_q + MAX_LEN_LOG'(1);
            end
            if (elem_next) begin
                p_d = '0;
                if (last_j) begin
                    j_d = '0;
                    // Hold i on the final element so it never walks past M-1.
                    if (!last_elem) begin
                        i_d = i_q + MAX_LEN_LOG'(1);
                    end
                end else begin
                    j_d = j_q + MAX_LEN_LOG'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q <= '0;
            j_q <= '0;
            p_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
            p_q <= p_d;
        end
    end

    // Bounds were checked before counting starts, so modulo-2^ADDR_WIDTH
    // arithmetic yields the exact address.
    assign a_addr = a_base + ADDR_WIDTH'(i_q) * ADDR_WIDTH'(dim_k) + ADDR_WIDTH'(p_q);
    assign b_addr = b_base + ADDR_WIDTH'(p_q) * ADDR_WIDTH'(dim_n) + ADDR_WIDTH'(j_q);
    assign c_addr = c_base + ADDR_WIDTH'(i_q) * ADDR_WIDTH'(dim_n) + ADDR_WIDTH'(j_q);

endmodule

// File: rtl/matmul_dpram.sv
// -----------------------------------------------------------------------------
// matmul_dpram
// Dual-port word memory with registered read data (1-cycle read latency).
// Port a: read/write. Port b: read only. Reads return the old word on a
// same-address write. Contents are never reset.
//   clk     in   clock
//   we_a    in   port a write enable
//   addr_a  in   port a address
//   din_a   in   port a write data
//   q_a     out  port a read data (registered)
//   addr_b  in   port b address
//   q_b     out  port b read data (registered)
// -----------------------------------------------------------------------------
module matmul_dpram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] din_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] q_b
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= din_a;
        end
        q_a <= mem[addr_a];
        q_b <= mem[addr_b];
    end

endmodule

// File: rtl/matmul_engine.sv
// -----------------------------------------------------------------------------
// matmul_engine
// Computes C = A x B (signed, row-major) from a shared word memory. The host
// owns memory port a while idle; during a run port a carries A reads and C
// writes and port b carries B reads.
//   clk, reset_n           clock, asynchronous active-low reset
//   host_we/addr/din       host write strobe, word address, write data
//   host_dout              host read data, one cycle after the address
//   start                  launch pulse, accepted only in IDLE
//   dim_m, dim_k, dim_n    A is MxK, B is KxN, C is MxN
//   a_base, b_base, c_base base word addresses
//   busy                   high from start acceptance through DONE
//   done                   one-cycle completion pulse
//   error                  dimension/address fault (sticky to next start)
//   overflow               a C element exceeded signed DATA_WIDTH (sticky)
//
// Control handshake: start is sampled only while busy is low; a sampled start
// latches dims and bases and raises busy on the same edge. Exactly one of
// {done pulse, error rise with busy falling} ends every accepted start.
// -----------------------------------------------------------------------------
module matmul_engine
    import matmul_engine_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int MAX_LEN     = DEF_MAX_LEN,
    parameter int MAX_LEN_LOG = DEF_MAX_LEN_LOG,
    parameter int ACC_WIDTH   = 2 * DATA_WIDTH + MAX_LEN_LOG
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   host_we,
    input  logic [ADDR_WIDTH-1:0]  host_addr,
    input  logic [DATA_WIDTH-1:0]  host_din,
    output logic [DATA_WIDTH-1:0]  host_dout,
    input  logic                   start,
    input  logic [MAX_LEN_LOG-1:0] dim_m,
    input  logic [MAX_LEN_LOG-1:0] dim_k,
    input  logic [MAX_LEN_LOG-1:0] dim_n,
    input  logic [ADDR_WIDTH-1:0]  a_base,
    input  logic [ADDR_WIDTH-1:0]  b_base,
    input  logic [ADDR_WIDTH-1:0]  c_base,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic                   overflow
);

    // Wide enough for base + largest dim product without wrapping.
    localparam int EW = ADDR_WIDTH + 2 * MAX_LEN_LOG + 1;
    localparam logic [EW-1:0] ADDR_SPAN = EW'(1) << ADDR_WIDTH;

    state_e                  state_q, state_d;
    logic [MAX_LEN_LOG-1:0]  dim_m_q, dim_m_d;
    logic [MAX_LEN_LOG-1:0]  dim_k_q, dim_k_d;
    logic [MAX_LEN_LOG-1:0]  dim_n_q, dim_n_d;
    logic [ADDR_WIDTH-1:0]   a_base_q, a_base_d;
    logic [ADDR_WIDTH-1:0]   b_base_q, b_base_d;
    logic [ADDR_WIDTH-1:0]   c_base_q, c_base_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                    mac_vld_q, mac_vld_d;
    logic                    error_q, error_d;
    logic                    overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0]   dout_hold_q, dout_hold_d;
    logic                    host_phase_q, host_phase_d;

    logic                    idle;
    logic                    ag_clear, ag_p_inc, ag_elem_next;
    logic [ADDR_WIDTH-1:0]   a_addr, b_addr, c_addr;
    logic                    last_p, last_elem;
    logic                    mem_we_a;
    logic [ADDR_WIDTH-1:0]   mem_addr_a;
    logic [DATA_WIDTH-1:0]   mem_din_a;
    logic [DATA_WIDTH-1:0]   q_a, q_b;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic                    acc_fits;
    logic                    dims_bad, range_bad;

    assign idle = (state_q == IDLE);

    matmul_addr_gen #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .MAX_LEN_LOG (MAX_LEN_LOG)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (reset_n),
        .clear     (ag_clear),
        .p_inc     (ag_p_inc),
        .elem_next (ag_elem_next),
        .dim_m     (dim_m_q),
        .dim_k     (dim_k_q),
        .dim_n     (dim_n_q),
        .a_base    (a_base_q),
        .b_base    (b_base_q),
        .c_base    (c_base_q),
        .a_addr    (a_addr),
        .b_addr    (b_addr),
        .c_addr    (c_addr),
        .last_p    (last_p),
        .last_elem (last_elem)
    );

    // Port a belongs to the host only in IDLE; busy-time host traffic is dropped.
    assign mem_we_a   = idle ? host_we   : (state_q == WRITE);
    assign mem_addr_a = idle ? host_addr : ((state_q == WRITE) ? c_addr : a_addr);
    assign mem_din_a  = idle ? host_din  : acc_q[DATA_WIDTH-1:0];

    matmul_dpram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk    (clk),
        .we_a   (mem_we_a),
        .addr_a (mem_addr_a),
        .din_a  (mem_din_a),
        .q_a    (q_a),
        .addr_b (b_addr),
        .q_b    (q_b)
    );

    // q_a reflects a host read only when the previous cycle was IDLE; otherwise
    // host_dout holds the last value the host saw.
    assign host_dout    = host_phase_q ? q_a : dout_hold_q;
    assign dout_hold_d  = host_dout;
    assign host_phase_d = idle;

    assign prod     = $signed(q_a) * $signed(q_b);
    assign prod_ext = {{(ACC_WIDTH - 2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};

    // Fits signed DATA_WIDTH iff all bits from the DATA_WIDTH sign bit up agree.
    assign acc_fits = (&acc_q[ACC_WIDTH-1:DATA_WIDTH-1]) || !(|acc_q[ACC_WIDTH-1:DATA_WIDTH-1]);

    assign dims_bad = (dim_m_q == '0) || (dim_k_q == '0) || (dim_n_q == '0) ||
                      (dim_m_q > MAX_LEN_LOG'(MAX_LEN)) ||
                      (dim_k_q > MAX_LEN_LOG'(MAX_LEN)) ||
                      (dim_n_q > MAX_LEN_LOG'(MAX_LEN));

    assign range_bad = (EW'(a_base_q) + EW'(dim_m_q) * EW'(dim_k_q) > ADDR_SPAN) ||
                       (EW'(b_base_q) + EW'(dim_k_q) * EW'(dim_n_q) > ADDR_SPAN) ||
                       (EW'(c_base_q) + EW'(dim_m_q) * EW'(dim_n_q) > ADDR_SPAN);

    always_comb begin
        state_d      = state_q;
        dim_m_d      = dim_m_q;
        dim_k_d      = dim_k_q;
        dim_n_d      = dim_n_q;
        a_base_d     = a_base_q;
        b_base_d     = b_base_q;
        c_base_d     = c_base_q;
        error_d      = error_q;
        overflow_d   = overflow_q;
        acc_d        = acc_q;
        mac_vld_d    = (state_q == MAC);
        ag_clear     = 1'b0;
        ag_p_inc     = 1'b0;
        ag_elem_next = 1'b0;

        // Read data lands one cycle after each MAC issue (incl. the DRAIN cycle).
        if (mac_vld_q) begin
            acc_d = acc_q + prod_ext;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = CHECK;
                    dim_m_d    = dim_m;
                    dim_k_d    = dim_k;
                    dim_n_d    = dim_n;
                    a_base_d   = a_base;
                    b_base_d   = b_base;
                    c_base_d   = c_base;
                    error_d    = 1'b0;
                    overflow_d = 1'b0;
                    ag_clear   = 1'b1;
                end
            end
            CHECK: begin
                if (dims_bad || range_bad) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = MAC;
                    acc_d   = '0;
                end
            end
            MAC: begin
                ag_p_inc = 1'b1;
                if (last_p) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = WRITE;
            end
            WRITE: begin
                ag_elem_next = 1'b1;
                if (!acc_fits) begin
                    overflow_d = 1'b1;
                end
                if (last_elem) begin
                    state_d = DONE;
                end else begin
                    state_d = MAC;
                    acc_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            dim_m_q      <= '0;
            dim_k_q      <= '0;
            dim_n_q      <= '0;
            a_base_q     <= '0;
            b_base_q     <= '0;
            c_base_q     <= '0;
            acc_q        <= '0;
            mac_vld_q    <= 1'b0;
            error_q      <= 1'b0;
            overflow_q   <= 1'b0;
            dout_hold_q  <= '0;
            host_phase_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dim_m_q      <= dim_m_d;
            dim_k_q      <= dim_k_d;
            dim_n_q      <= dim_n_d;
            a_base_q     <= a_base_d;
            b_base_q     <= b_base_d;
            c_base_q     <= c_base_d;
            acc_q        <= acc_d;
            mac_vld_q    <= mac_vld_d;
            error_q      <= error_d;
            overflow_q   <= overflow_d;
            dout_hold_q  <= dout_hold_d;
            host_phase_q <= host_phase_d;
        end
    end

    assign busy     = !idle;
    assign done     = (state_q == DONE);
    assign error    = error_q;
    assign overflow = overflow_q;

endmodule

// File: doc/matmul_engine.md
MATMUL_ENGINE -- requirements
Module: matmul_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, element width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, memory address width.
REQ-003 SHALL have parameter MAX_LEN, default 100, maximum for any matrix dimension.
REQ-004 SHALL have parameter MAX_LEN_LOG, default 7, width of dimension ports.
REQ-005 SHALL have parameter ACC_WIDTH, default 2*DATA_WIDTH+MAX_LEN_LOG, accumulator width.
REQ-006 Ports, in order:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- host_we  in  1  host write strobe.
- host_addr  in  ADDR_WIDTH  host word address.
- host_din  in  DATA_WIDTH  host write data.
- host_dout  out  DATA_WIDTH  host read data, one cycle after the address.
- start  in  1  single-cycle launch pulse.
- dim_m, dim_k, dim_n  in  MAX_LEN_LOG each  A is MxK, B is KxN, C is MxN.
- a_base, b_base, c_base  in  ADDR_WIDTH each  row-major base addresses.
- busy  out  1  high from the start acceptance through the DONE state.
- done  out  1  one-cycle completion pulse.
- error  out  1  dimension or address fault, sticky until the next accepted start.
- overflow  out  1  some C element did not fit signed DATA_WIDTH, sticky until the next accepted start.

Function
REQ-007 SHALL instantiate the team dual-port memory (registered q, 1-cycle read latency): port a is shared by the host, A reads and C writes; port b is used for B reads only.
REQ-008 When idle, port a SHALL be driven by the host (host_we/addr/din); host_dout = q_a.
REQ-009 While busy, the host SHALL be ignored: host writes dropped, host_dout holds its last value.
REQ-010 FSM states SHALL be: IDLE, CHECK, MAC, DRAIN, WRITE, DONE.
REQ-011 IDLE->CHECK on start=1. Dims and bases are latched on that edge. error and overflow are cleared on that edge.
REQ-012 CHECK (1 cycle) SHALL set error and go to IDLE, without asserting done, if any of the following holds:
- any dim = 0;
- any dim > MAX_LEN;
- a_base+M*K, b_base+K*N or c_base+M*N > 2^ADDR_WIDTH.
Otherwise it SHALL go to MAC with i=j=p=0.
REQ-013 MAC SHALL last K cycles. Each cycle it issues A at a_base+i*K+p and B at b_base+p*N+j, with p incrementing.
REQ-014 The accumulator SHALL add the signed product of q_a and q_b one cycle after each issue. It is zeroed on entry to MAC.
REQ-015 DRAIN (1 cycle) SHALL absorb the final product.
REQ-016 WRITE (1 cycle) SHALL write the low DATA_WIDTH bits of the accumulator to c_base+i*N+j via port a. overflow is set if the accumulator lies outside the signed DATA_WIDTH range.
REQ-017 After WRITE, j SHALL increment. At j=N-1, j wraps to 0 and i increments. After i=M-1, j=N-1 the FSM goes to DONE, else back to MAC.
REQ-018 DONE SHALL assert done for exactly 1 cycle, then go to IDLE; busy drops in the same cycle done drops.
REQ-019 Latency from the start edge to the done-high cycle SHALL be exactly 1+M*N*(K+2) cycles.
REQ-020 start while busy SHALL be ignored.
REQ-021 In-place aliasing (the C region overlapping A or B) is undefined; no check is required.
REQ-022 All arithmetic SHALL be two's-complement signed. Products are sign-extended to ACC_WIDTH.

Reset
REQ-023 reset_n low SHALL force IDLE and set busy=0, done=0, error=0, overflow=0, host_dout=0, and all counters and the accumulator to 0.
REQ-024 Reset mid-operation SHALL abort without further memory writes. Memory contents are not reset; partially written C is retained.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding and the default constants DATA_WIDTH, ADDR_WIDTH, MAX_LEN, MAX_LEN_LOG.
REQ-026 The index/address generator (i, j, p counters and the three address computations) SHALL be one sub-module, matmul_addr_gen.

Verification
REQ-027 2x2x2: A=[1,2;3,4], B=identity -> C=[1,2;3,4]; done exactly 17 cycles after start; error=0, overflow=0.
REQ-028 1x1x1: A=-3, B=7 -> C=-21 (0xFFFFFFEB); done at cycle 4.
REQ-029 dim_k=0 or dim_m=101 -> error=1 one cycle after CHECK; done never asserts; memory unchanged.
REQ-030 K=2, A=B=0x7FFFFFFF -> overflow=1; the C word equals the low 32 bits of the sum.
REQ-031 A second start and host writes during a 3x3x3 run -> both ignored; C correct; done after 1+9*5=46 cycles.
REQ-032 reset_n pulsed low mid-MAC -> busy/done/error/overflow drop immediately; a subsequent normal run completes correctly.
